// File: rtl/eth_pkg.sv
// Shared Ethernet receive-path types.
//   byte_t          : one octet from the MII RX MAC
//   RX_BUF_ADDR_W   : default log2 depth of the RX frame buffer (bytes)
//   rx_buf_entry_t  : one buffer entry, the byte plus its end-of-frame flag
//   wr_state_t      : write-side state of the frame commit controller
package eth_pkg;

    typedef logic [7:0] byte_t;

    localparam int RX_BUF_ADDR_W = 11;

    typedef struct packed {
        logic  last;
        byte_t data;
    } rx_buf_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        OVF  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/frame_buf_ram.sv
// Simple dual-port frame buffer, 2**ADDR_W entries of {last, byte}.
// One write port, one read port with a registered (1-cycle) read.
// The array has no reset; readers qualify rd_data with their own valid.
//   rx_clk  : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : entry to write
//   rd_en   : read strobe, rd_data updates on the next edge
//   rd_addr : read address
//   rd_data : registered read data
module frame_buf_ram
    import eth_pkg::*;
#(
    parameter int ADDR_W = RX_BUF_ADDR_W
) (
    input  logic              rx_clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  rx_buf_entry_t     wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output rx_buf_entry_t     rd_data
);

    rx_buf_entry_t mem [2**ADDR_W];

    always_ff @(posedge rx_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rx_frame_commit_ctrl.sv
// Store-and-forward gate between the MAC RX byte stream and the UDP parser.
// Frames are written speculatively into a circular buffer and only become
// readable once committed by frame_valid; errors and overflow roll back.
//   rx_clk, rst_n        : clock, async active-low reset
//   data_in, wr_en       : byte stream from the MAC
//   frame_valid          : CRC-good end of frame (with last byte)
//   frame_err            : frame error, rolls the current frame back
//   m_data/m_last/m_valid/m_ready : committed-frame read port
//   buf_level            : committed bytes not yet accepted downstream
//   frames_ok/frames_drop: saturating committed / rolled-back frame counts
//
// state | meaning
// IDLE  | between frames, next wr_en starts a frame
// OPEN  | frame in progress, bytes being stored
// OVF   | buffer filled mid-frame, rest of frame discarded until it ends
module rx_frame_commit_ctrl
    import eth_pkg::*;
#(
    parameter int ADDR_W = RX_BUF_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              rx_clk,
    input  logic              rst_n,
    input  byte_t             data_in,
    input  logic              wr_en,
    input  logic              frame_valid,
    input  logic              frame_err,
    output byte_t             m_data,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W:0]   buf_level,
    output logic [CNT_W-1:0]  frames_ok,
    output logic [CNT_W-1:0]  frames_drop
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    wr_state_t       state;
    // rd_ptr tracks bytes accepted downstream; fetch_ptr runs ahead of it
    // into the output/skid registers. Space is freed only at rd_ptr.
    logic [ADDR_W:0] wr_ptr, commit_ptr, rd_ptr, fetch_ptr;
    logic [ADDR_W:0] wr_ptr_nxt, commit_ptr_nxt, rd_ptr_nxt;
    logic            full, frame_act, accept, overflow, do_rollback, do_commit;

    logic            pop, issue, rd_pend, skid_valid;
    logic [1:0]      occ;
    rx_buf_entry_t   rd_data, skid;

    always_comb begin
        full      = (wr_ptr - rd_ptr) == DEPTH;
        frame_act = (state != IDLE) || wr_en;
        accept    = wr_en && !full && (state != OVF);
        overflow  = wr_en && full && (state != OVF);
        // A frame that lost a byte to overflow can never be committed.
        do_rollback = frame_act &&
                      (frame_err || (frame_valid && ((state == OVF) || overflow)));
        do_commit   = frame_act && frame_valid && !do_rollback;

        wr_ptr_nxt     = do_rollback ? commit_ptr : wr_ptr + (ADDR_W+1)'(accept);
        commit_ptr_nxt = do_commit ? wr_ptr_nxt : commit_ptr;
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            frames_ok   <= '0;
            frames_drop <= '0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            if (do_rollback) begin
                state <= IDLE;
                if (frames_drop != '1) begin
                    frames_drop <= frames_drop + CNT_W'(1);
                end
            end else if (do_commit) begin
                state <= IDLE;
                if (frames_ok != '1) begin
                    frames_ok <= frames_ok + CNT_W'(1);
                end
            end else if (overflow) begin
                state <= OVF;
            end else if (accept) begin
                state <= OPEN;
            end
        end
    end

    frame_buf_ram #(.ADDR_W(ADDR_W)) u_ram (
        .rx_clk  (rx_clk),
        .wr_en   (accept),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data ('{last: frame_valid, data: data_in}),
        .rd_en   (issue),
        .rd_addr (fetch_ptr[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    // Output register, skid register and the read in flight together hold
    // at most two entries, so a stalled port never loses returning data.
    always_comb begin
        pop        = m_valid && m_ready;
        occ        = 2'(m_valid) + 2'(skid_valid) + 2'(rd_pend) - 2'(pop);
        issue      = (fetch_ptr != commit_ptr) && (occ < 2'd2);
        rd_ptr_nxt = rd_ptr + (ADDR_W+1)'(pop);
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_ptr  <= '0;
            rd_ptr     <= '0;
            rd_pend    <= 1'b0;
            skid_valid <= 1'b0;
            skid       <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            buf_level  <= '0;
        end else begin
            fetch_ptr <= fetch_ptr + (ADDR_W+1)'(issue);
            rd_pend   <= issue;
            rd_ptr    <= rd_ptr_nxt;
            buf_level <= commit_ptr_nxt - rd_ptr_nxt;
            if (!m_valid || m_ready) begin
                if (skid_valid) begin
                    m_valid    <= 1'b1;
                    m_data     <= skid.data;
                    m_last     <= skid.last;
                    skid       <= rd_data;
                    skid_valid <= rd_pend;
                end else if (rd_pend) begin
                    m_valid <= 1'b1;
                    m_data  <= rd_data.data;
                    m_last  <= rd_data.last;
                end else begin
                    m_valid <= 1'b0;
                end
            end else if (rd_pend) begin
                skid       <= rd_data;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule
